counting_bloom_ctrl: RTL and testbench
======================================

Name: counting_bloom_ctrl

Overview:
Operation sequencer upstream of the bank of 8-bit LFSR counting cells in the counting Bloom filter. It accepts query, insert, delete and clear requests on a key, and derives NUM_HASH counter indices by double hashing. It probes the selected cells, then drives their per-cell write-enable and increment/decrement lines. It returns membership, overflow and error status through a ready/valid response.

Parameters:
KEY_W, 16, key width in bits
IDX_W, 6, counter index width; NUM_CTRS = 2**IDX_W
NUM_HASH, 3, hash functions per key (K), 1..8

Ports:
CLK  in  1  clock; all state changes on the rising edge
rstb  in  1  asynchronous active-low reset
op_valid  in  1  request valid
op_ready  out  1  controller idle; request accepted when op_valid & op_ready
op_code  in  2  00 query, 01 insert, 10 delete, 11 clear-all
op_key  in  KEY_W  key, captured on accept
res_valid  out  1  response valid, held until res_ready
res_ready  in  1  response consumed
res_member  out  1  1 = no probed cell was zero (pre-operation)
res_ovf  out  1  insert aborted, probed cell at overflow
res_err  out  1  delete aborted, probed cell already zero
ctr_sel  out  IDX_W  index of the cell under probe/update
ctr_we  out  NUM_CTRS  one-hot per-cell WE, all zero when not updating
ctr_inc  out  1  1 = increment, 0 = decrement; meaningful while ctr_we != 0
ctr_clr  out  1  active-high synchronous clear to every cell
ctr_zero  in  NUM_CTRS  per-cell Zero outputs
ctr_of  in  NUM_CTRS  per-cell OF outputs

Behaviour:
- Hash: a = XOR of all IDX_W-bit chunks of key, with the top chunk zero-padded. b = rotate-left-1(a) | 1, so b is odd. h_i = (a + i*b) mod NUM_CTRS for i = 0..K-1.
- FSM states are IDLE, PROBE, UPDATE, CLEAR and RESP.
- Reset (async): state IDLE, op_ready=1, res_valid/member/ovf/err=0, ctr_we=0, ctr_clr=0, ctr_sel=0, ctr_inc=0. Reset mid-operation abandons the operation immediately; cells already written are not rolled back.
- Cycle 0 is the accept cycle. Key and op are registered, and op_ready drops in cycle 1.
- PROBE, cycles 1..K: ctr_sel=h_(cycle-1) and ctr_we=0.
  - Each cycle samples ctr_zero[ctr_sel] and ctr_of[ctr_sel] into sticky any_zero/any_of flags.
  - With WE low, the cell's Zero reflects its current value.
- After PROBE:
  - query (code 00): go to RESP.
  - insert (code 01) with any_of: RESP with res_ovf=1 and no writes (atomic abort).
  - delete (code 10) with any_zero: RESP with res_err=1 and no writes.
  - otherwise: UPDATE.
- UPDATE, cycles K+1..2K: ctr_sel=h_i, ctr_we = one-hot(h_i) for exactly one cycle each, ctr_inc=1 for insert and 0 for delete.
  - Duplicate indices (h_i == h_j) are written once per occurrence.
  - Overflow saturation is enforced by the cell, not here.
- CLEAR (code 11): ctr_clr=1 for exactly cycle 1, then RESP. res_member=0, res_ovf=0, res_err=0.
- RESP: res_valid=1 from cycle K+1 (query/aborted), 2K+1 (updated) or 2 (clear).
  - Outputs stay stable until a cycle with res_ready=1.
  - The next cycle returns to IDLE with op_ready=1, so there is one-deep turnaround and no op/response overlap.
- res_member always reports membership before the operation: !any_zero.
- ctr_we and ctr_clr are never asserted in the same cycle. Both are zero in IDLE, PROBE and RESP.

Optional Feature:
BLOOM_STATS_EN defined: adds output stat_items [15:0]. It resets to 0 and clears on a clear op. It increments by 1 on each completed insert, saturating at 0xFFFF, and decrements by 1 on each completed delete, saturating at 0. It updates in the RESP entry cycle. Undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Assert rstb=0 mid-UPDATE of an insert -> same cycle ctr_we=0, res_valid=0; after release op_ready=1 and state is IDLE.
- Query key 0x0003 on a cleared bank (a=3, b=7, h=3,10,17) -> ctr_sel 3,10,17 in cycles 1-3; res_valid cycle 4 with res_member=0, ctr_we=0 throughout.
- Insert 0x0003 -> ctr_we bits 3,10,17 one-hot in cycles 4,5,6 with ctr_inc=1; res_valid cycle 7 with member=0. A following query of 0x0003 -> res_member=1.
- Delete 0x0000 (h=0,1,2) with only 0x0003 inserted -> res_err=1 at cycle 4, no ctr_we pulse. Delete 0x0003 -> ctr_inc=0 pulses on 3,10,17; a re-query then gives member=0.
- Insert 0x0003 with ctr_of[10] forced 1 -> res_ovf=1 at cycle 4, no ctr_we. Clear op -> single ctr_clr pulse in cycle 1, res_valid cycle 2; with BLOOM_STATS_EN, stat_items=0.
- Hold res_ready=0 for 5 cycles after a query -> res_valid and result bits stable, op_ready=0, and an op_valid pulse is ignored; on res_ready=1, op_ready=1 the next cycle.

Source files
------------

// File: rtl/counting_bloom_ctrl.sv
// Operation sequencer for a counting Bloom filter: double-hashes each key into NUM_HASH cell
// indices, probes them, then increments/decrements them. Define BLOOM_STATS_EN to add stat_items.
module counting_bloom_ctrl #(
    parameter int KEY_W    = 16,
    parameter int IDX_W    = 6,
    parameter int NUM_HASH = 3
) (
    input  logic                  CLK,
    input  logic                  rstb,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op_code,
    input  logic [KEY_W-1:0]      op_key,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_member,
    output logic                  res_ovf,
    output logic                  res_err,
    output logic [IDX_W-1:0]      ctr_sel,
    output logic [2**IDX_W-1:0]   ctr_we,
    output logic                  ctr_inc,
    output logic                  ctr_clr,
    input  logic [2**IDX_W-1:0]   ctr_zero,
    input  logic [2**IDX_W-1:0]   ctr_of
`ifdef BLOOM_STATS_EN
    ,
    output logic [15:0]           stat_items
`endif
);
    localparam int         NUM_CTRS = 2**IDX_W;
    localparam int         NCHUNK   = (KEY_W + IDX_W - 1) / IDX_W;
    localparam logic [2:0] LAST_IDX = 3'(NUM_HASH - 1);

    typedef enum logic [2:0] {IDLE, PROBE, UPDATE, CLEAR, RESP} state_t;
    typedef enum logic [1:0] {OP_QUERY, OP_INSERT, OP_DELETE, OP_CLEAR} op_t;

    state_t           state, state_nx;
    op_t              op_q;
    logic [2:0]       cnt;
    logic             any_zero, any_of;
    logic [IDX_W-1:0] a_q, b_q, cur_h, key_a;
    logic             last, probe_zero, probe_of, zero_all, of_all, abort;

    // First hash: XOR-fold of the key in IDX_W-bit chunks, top chunk zero-padded.
    function automatic logic [IDX_W-1:0] hash_a(input logic [KEY_W-1:0] key);
        logic [NCHUNK*IDX_W-1:0] padded;
        logic [IDX_W-1:0]        acc;
        padded             = '0;
        padded[KEY_W-1:0]  = key;
        acc                = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            acc = acc ^ padded[i*IDX_W +: IDX_W];
        end
        return acc;
    endfunction

    // Second hash is forced odd so the stride visits distinct cells before wrapping.
    function automatic logic [IDX_W-1:0] hash_b(input logic [IDX_W-1:0] a);
        return {a[IDX_W-2:0], a[IDX_W-1]} | IDX_W'(1);
    endfunction

    assign key_a      = hash_a(op_key);
    assign last       = (cnt == LAST_IDX);
    assign probe_zero = ctr_zero[cur_h];
    assign probe_of   = ctr_of[cur_h];
    assign zero_all   = any_zero | probe_zero;
    assign of_all     = any_of | probe_of;
    assign abort      = ((op_q == OP_INSERT) && of_all) || ((op_q == OP_DELETE) && zero_all);

    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        ctr_sel   = '0;
        ctr_we    = '0;
        ctr_inc   = 1'b0;
        ctr_clr   = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_nx = (op_t'(op_code) == OP_CLEAR) ? CLEAR : PROBE;
                end
            end
            PROBE: begin
                ctr_sel = cur_h;
                if (last) begin
                    state_nx = ((op_q == OP_QUERY) || abort) ? RESP : UPDATE;
                end
            end
            UPDATE: begin
                ctr_sel = cur_h;
                ctr_we  = {{(NUM_CTRS-1){1'b0}}, 1'b1} << cur_h;
                ctr_inc = (op_q == OP_INSERT);
                if (last) begin
                    state_nx = RESP;
                end
            end
            CLEAR: begin
                ctr_clr  = 1'b1;
                state_nx = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Probe bookkeeping; result bits are fixed at the end of the probe, before any write.
    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            cnt        <= '0;
            any_zero   <= 1'b0;
            any_of     <= 1'b0;
            res_member <= 1'b0;
            res_ovf    <= 1'b0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        cnt      <= '0;
                        any_zero <= 1'b0;
                        any_of   <= 1'b0;
                    end
                end
                PROBE: begin
                    any_zero <= zero_all;
                    any_of   <= of_all;
                    cnt      <= last ? 3'd0 : cnt + 3'd1;
                    if (last) begin
                        res_member <= !zero_all;
                        res_ovf    <= (op_q == OP_INSERT) && of_all;
                        res_err    <= (op_q == OP_DELETE) && zero_all;
                    end
                end
                UPDATE: cnt <= cnt + 3'd1;
                CLEAR: begin
                    res_member <= 1'b0;
                    res_ovf    <= 1'b0;
                    res_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Hash datapath: cur_h walks a, a+b, a+2b ... and is rewound to a for the update pass.
    always_ff @(posedge CLK) begin
        if ((state == IDLE) && op_valid) begin
            op_q  <= op_t'(op_code);
            a_q   <= key_a;
            b_q   <= hash_b(key_a);
            cur_h <= key_a;
        end else if (state == PROBE) begin
            cur_h <= last ? a_q : cur_h + b_q;
        end else if (state == UPDATE) begin
            cur_h <= cur_h + b_q;
        end
    end

`ifdef BLOOM_STATS_EN
    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            stat_items <= '0;
        end else if (state == CLEAR) begin
            stat_items <= '0;
        end else if ((state == UPDATE) && last) begin
            if ((op_q == OP_INSERT) && (stat_items != 16'hFFFF)) begin
                stat_items <= stat_items + 16'd1;
            end else if ((op_q == OP_DELETE) && (stat_items != 16'h0000)) begin
                stat_items <= stat_items - 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_counting_bloom_ctrl.sv
// Scoreboard bench for counting_bloom_ctrl: an abstract counter-array model predicts responses
// and write sequences; a small saturating cell-bank model answers the DUT's probes.
module tb_counting_bloom_ctrl;
    localparam int KEY_W = 16;
    localparam int IDX_W = 6;
    localparam int K     = 3;
    localparam int NC    = 2**IDX_W;
    localparam int OFMAX = 3;

    typedef struct packed {
        logic        member;
        logic        ovf;
        logic        err;
        logic [15:0] stat;
    } rsp_t;

    typedef struct packed {
        logic [7:0] idx;
        logic       inc;
    } wr_t;

    logic             CLK = 1'b0;
    logic             rstb;
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_code;
    logic [KEY_W-1:0] op_key;
    logic             res_valid;
    wire              res_ready;
    logic             res_member, res_ovf, res_err;
    logic [IDX_W-1:0] ctr_sel;
    logic [NC-1:0]    ctr_we;
    logic             ctr_inc, ctr_clr;
    logic [NC-1:0]    ctr_zero, ctr_of;
`ifdef BLOOM_STATS_EN
    logic [15:0]      stat_items;
`endif

    int   bank [NC] = '{default: 0};
    int   ref_c [NC];
    int   force_of;
    int   n_checks, n_errors;
    int   stat_exp, clr_exp, clr_cnt;
    bit   mon_en, bp_rand, bp_val, man_ready;
    rsp_t exp_res [$];
    wr_t  exp_wr  [$];
    rsp_t mon_r;
    wr_t  mon_w;
    int   mon_idx, mon_bad;
    int   pool [8];

    assign res_ready = bp_rand ? bp_val : man_ready;

    always #5 CLK = ~CLK;

    counting_bloom_ctrl #(.KEY_W(KEY_W), .IDX_W(IDX_W), .NUM_HASH(K)) dut (
        .CLK(CLK), .rstb(rstb), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_key(op_key), .res_valid(res_valid), .res_ready(res_ready),
        .res_member(res_member), .res_ovf(res_ovf), .res_err(res_err),
        .ctr_sel(ctr_sel), .ctr_we(ctr_we), .ctr_inc(ctr_inc), .ctr_clr(ctr_clr),
        .ctr_zero(ctr_zero), .ctr_of(ctr_of)
`ifdef BLOOM_STATS_EN
        , .stat_items(stat_items)
`endif
    );

    // Cell bank: saturating counters 0..OFMAX, synchronous clear.
    always @(posedge CLK) begin
        for (int i = 0; i < NC; i++) begin
            if (ctr_clr) bank[i] <= 0;
            else if (ctr_we[i]) begin
                if (ctr_inc) bank[i] <= (bank[i] < OFMAX) ? bank[i] + 1 : bank[i];
                else         bank[i] <= (bank[i] > 0) ? bank[i] - 1 : 0;
            end
        end
    end

    always_comb begin
        ctr_zero = '0;
        ctr_of   = '0;
        for (int i = 0; i < NC; i++) begin
            ctr_zero[i] = (bank[i] == 0);
            ctr_of[i]   = (bank[i] == OFMAX) || (i == force_of);
        end
    end

    always @(posedge CLK) begin
        #1 bp_val = ($urandom_range(0, 3) != 0);
    end

    function automatic int hidx(input int key, input int i);
        int a, b;
        a = 0;
        for (int s = 0; s < KEY_W; s += IDX_W) a = a ^ ((key >> s) & (NC - 1));
        b = (((a << 1) | (a >> (IDX_W - 1))) & (NC - 1)) | 1;
        return (a + i * b) % NC;
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_op(input int code, input int key, input bit hold);
        int   h [K];
        int   n, lat, exp_lat;
        bit   za, oa;
        rsp_t r;
        logic [2:0] hb;
        for (int i = 0; i < K; i++) h[i] = hidx(key, i);
        n = 0;
        @(posedge CLK); #1;
        while (!op_ready && n < 100) begin @(posedge CLK); #1; n++; end
        check(op_ready == 1'b1, "ready_wait", op_ready, 1);
        if (!op_ready) return;
        za = 0; oa = 0;
        for (int i = 0; i < K; i++) begin
            if (ref_c[h[i]] == 0) za = 1;
            if (ref_c[h[i]] == OFMAX || h[i] == force_of) oa = 1;
        end
        r = '0;
        r.member = !za;
        exp_lat = K + 1;
        case (code)
            1: if (oa) r.ovf = 1'b1;
               else begin
                   for (int i = 0; i < K; i++) begin
                       exp_wr.push_back('{idx: 8'(h[i]), inc: 1'b1});
                       if (ref_c[h[i]] < OFMAX) ref_c[h[i]]++;
                   end
                   exp_lat = 2 * K + 1;
                   if (stat_exp < 65535) stat_exp++;
               end
            2: if (za) r.err = 1'b1;
               else begin
                   for (int i = 0; i < K; i++) begin
                       exp_wr.push_back('{idx: 8'(h[i]), inc: 1'b0});
                       if (ref_c[h[i]] > 0) ref_c[h[i]]--;
                   end
                   exp_lat = 2 * K + 1;
                   if (stat_exp > 0) stat_exp--;
               end
            3: begin
                   r.member = 1'b0;
                   for (int i = 0; i < NC; i++) ref_c[i] = 0;
                   exp_lat = 2;
                   stat_exp = 0;
                   clr_exp++;
               end
            default: ;
        endcase
        r.stat = 16'(stat_exp);
        exp_res.push_back(r);
        op_valid = 1'b1; op_code = 2'(code); op_key = 16'(key);
        @(posedge CLK); #1;
        op_valid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(negedge CLK);
            lat++;
            if (res_valid) break;
            check(op_ready == 1'b0, "busy_ready", op_ready, 0);
            if (code == 3) check(ctr_clr == 1'b1, "clr_pulse", ctr_clr, 1);
            else if (lat <= K) begin
                check(int'(ctr_sel) == h[lat-1], "probe_sel", ctr_sel, h[lat-1]);
                check(ctr_we == '0, "probe_no_we", $countones(ctr_we), 0);
            end
        end
        check(lat == exp_lat, "latency", lat, exp_lat);
        if (hold) begin
            hb = {res_member, res_ovf, res_err};
            for (int c = 0; c < 5; c++) begin
                @(posedge CLK); #1;
                op_valid = (c == 1); op_code = 2'b01; op_key = 16'h0055;
                @(negedge CLK);
                check(res_valid == 1'b1, "hold_valid", res_valid, 1);
                check({res_member, res_ovf, res_err} == hb, "hold_bits", {res_member, res_ovf, res_err}, hb);
                check(op_ready == 1'b0, "hold_ready", op_ready, 0);
            end
            @(posedge CLK); #1; op_valid = 1'b0; man_ready = 1'b1;
            @(negedge CLK);
            @(posedge CLK); #1; man_ready = 1'b0;
            @(negedge CLK);
            check(op_ready == 1'b1, "ready_after_resp", op_ready, 1);
            man_ready = 1'b1;
        end else begin
            n = 0;
            while (res_valid && n < 200) begin @(negedge CLK); n++; end
            check(res_valid == 1'b0, "res_drain", res_valid, 0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rstb = 1'b0; op_valid = 1'b0; op_code = 2'b00; op_key = '0;
        force_of = -1; n_checks = 0; n_errors = 0; stat_exp = 0; clr_exp = 0; clr_cnt = 0;
        mon_en = 1'b1; bp_rand = 1'b0; man_ready = 1'b1;
        for (int i = 0; i < NC; i++) ref_c[i] = 0;
        pool[0] = 0; pool[1] = 3;
        for (int i = 2; i < 8; i++) pool[i] = $urandom_range(0, 65535);

        fork
            forever begin
                @(negedge CLK);
                if (rstb && mon_en) begin
                    if (ctr_we != '0) begin
                        check($onehot(ctr_we), "we_onehot", $countones(ctr_we), 1);
                        check(ctr_clr == 1'b0, "we_clr_excl", ctr_clr, 0);
                        mon_idx = 0;
                        for (int i = 0; i < NC; i++) if (ctr_we[i]) mon_idx = i;
                        check(int'(ctr_sel) == mon_idx, "upd_sel", ctr_sel, mon_idx);
                        check(exp_wr.size() > 0, "write_expected", 1, exp_wr.size());
                        if (exp_wr.size() > 0) begin
                            mon_w = exp_wr.pop_front();
                            check(mon_idx == int'(mon_w.idx), "write_idx", mon_idx, mon_w.idx);
                            check(ctr_inc == mon_w.inc, "write_inc", ctr_inc, mon_w.inc);
                        end
                    end
                    if (res_valid && res_ready) begin
                        check(exp_res.size() > 0, "resp_expected", 0, 1);
                        if (exp_res.size() > 0) begin
                            mon_r = exp_res.pop_front();
                            check(res_member == mon_r.member, "res_member", res_member, mon_r.member);
                            check(res_ovf == mon_r.ovf, "res_ovf", res_ovf, mon_r.ovf);
                            check(res_err == mon_r.err, "res_err", res_err, mon_r.err);
`ifdef BLOOM_STATS_EN
                            check(stat_items == mon_r.stat, "stat_items", stat_items, mon_r.stat);
`endif
                        end
                        check(exp_wr.size() == 0, "writes_done", exp_wr.size(), 0);
                        mon_bad = 0;
                        for (int i = 0; i < NC; i++) if (bank[i] != ref_c[i]) mon_bad++;
                        check(mon_bad == 0, "bank_state", mon_bad, 0);
                    end
                    if (ctr_clr) clr_cnt++;
                end
            end
        join_none

        #3;
        check(op_ready == 1'b1, "rst_op_ready", op_ready, 1);
        check(res_valid == 1'b0, "rst_res_valid", res_valid, 0);
        check({res_member, res_ovf, res_err} == 3'b000, "rst_res_bits", {res_member, res_ovf, res_err}, 0);
        check(ctr_we == '0 && ctr_clr == 1'b0, "rst_we_clr", $countones(ctr_we) + ctr_clr, 0);
        check(ctr_sel == '0 && ctr_inc == 1'b0, "rst_sel_inc", ctr_sel + ctr_inc, 0);
        @(posedge CLK); #1 rstb = 1'b1;

        do_op(3, 0, 0);
        man_ready = 1'b0;
        do_op(0, 16'h0003, 1);
        do_op(1, 16'h0003, 0);
        do_op(0, 16'h0003, 0);
        do_op(2, 16'h0000, 0);
        do_op(2, 16'h0003, 0);
        do_op(0, 16'h0003, 0);
        force_of = 10;
        do_op(1, 16'h0003, 0);
        force_of = -1;
        do_op(3, 0, 0);

        // Reset in the middle of an insert's update pass.
        mon_en = 1'b0;
        @(posedge CLK); #1;
        op_valid = 1'b1; op_code = 2'b01; op_key = 16'h0003;
        @(posedge CLK); #1;
        op_valid = 1'b0;
        n = 0;
        while (ctr_we == '0 && n < 20) begin @(negedge CLK); n++; end
        check(ctr_we != '0, "upd_reach", $countones(ctr_we), 1);
        #2 rstb = 1'b0;
        #1;
        check(ctr_we == '0, "rst_mid_we", $countones(ctr_we), 0);
        check(res_valid == 1'b0, "rst_mid_res_valid", res_valid, 0);
        check(op_ready == 1'b1, "rst_mid_ready", op_ready, 1);
        repeat (2) @(posedge CLK);
        #1 rstb = 1'b1;
        @(negedge CLK);
        check(op_ready == 1'b1, "post_rst_ready", op_ready, 1);
        exp_wr.delete(); exp_res.delete();
        stat_exp = 0;
        mon_en = 1'b1;
        do_op(0, 16'h0003, 0);
        do_op(3, 0, 0);

        bp_rand = 1'b1;
        for (int t = 0; t < 300; t++) begin
            int r, code;
            r = $urandom_range(0, 99);
            code = (r < 30) ? 0 : (r < 70) ? 1 : (r < 95) ? 2 : 3;
            do_op(code, pool[$urandom_range(0, 7)], 0);
        end

        repeat (3) @(negedge CLK);
        check(exp_res.size() == 0, "resp_queue_empty", exp_res.size(), 0);
        check(clr_cnt == clr_exp, "clr_pulses", clr_cnt, clr_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
